a23_run_ctrl: RTL

Run controller that sequences one execution of the a23 garbled-circuit processor (`a23_gc_main`). On a start pulse it holds the core in reset for a programmable interval, then enables it. It counts execution cycles until the core raises `terminate` or a cycle budget expires. It then streams the output memory word by word over a valid/ready port. It sits between the host/test harness and the core, replacing ad-hoc reset/terminate polling.

---
 rtl/a23_run_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/a23_run_ctrl.sv
// Run controller for one a23_gc_main execution: reset hold, budgeted run,
// then a valid/ready unload of the core's output memory.
module a23_run_ctrl #(
  parameter int OUT_MEM_SIZE = 64,
  parameter int CC_W         = 32,
  parameter int RST_CYCLES   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CC_W-1:0]            max_cc,
  output logic                       core_rst,
  output logic                       core_en,
  input  logic                       core_terminate,
  input  logic [OUT_MEM_SIZE*32-1:0] o,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CC_W-1:0]            cycle_count
);

  localparam int IDX_W  = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  idx;
  logic [CC_W-1:0]   budget;
  logic [CC_W-1:0]   cc_inc;
  logic              budget_hit;
  logic              last_word;
  logic [31:0]       words [OUT_MEM_SIZE];

  for (genvar g = 0; g < OUT_MEM_SIZE; g++) begin : g_words
    assign words[g] = o[32*g +: 32];
  end

  assign cc_inc     = cycle_count + CC_W'(1);
  assign budget_hit = (budget != '0) && (cc_inc == budget);
  assign last_word  = (idx == IDX_W'(OUT_MEM_SIZE - 1));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_HOLD;
      S_HOLD:   if (hold_cnt == HOLD_W'(1)) state_nxt = S_RUN;
      S_RUN:    if (core_terminate || budget_hit) state_nxt = S_UNLOAD;
      S_UNLOAD: if (out_ready && last_word) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      idx         <= '0;
      budget      <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            budget      <= max_cc;
            cycle_count <= '0;
            timeout     <= 1'b0;
            hold_cnt    <= HOLD_W'(RST_CYCLES);
            idx         <= '0;
          end
        end
        S_HOLD: hold_cnt <= hold_cnt - HOLD_W'(1);
        S_RUN: begin
          // Terminate wins over a budget hit in the same cycle.
          if (!core_terminate) begin
            cycle_count <= cc_inc;
            if (budget_hit) timeout <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) idx <= last_word ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign core_rst  = (state == S_IDLE) || (state == S_HOLD);
  assign core_en   = (state == S_RUN);
  assign out_valid = (state == S_UNLOAD);
  assign out_data  = out_valid ? words[idx] : 32'h0;
  assign out_last  = out_valid && last_word;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
